// File: rtl/ctx_pkg.sv
// Shared definitions for the context stack: FSM encoding, mode width, default depth.
package ctx_pkg;

  localparam int unsigned MODE_W        = 2;
  localparam int unsigned DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RET  = 2'd1,
    ST_HOLD = 2'd2
  } ctx_state_e;

endpackage

// File: rtl/ctx_stack_mem.sv
// Context storage array with push/pop, occupancy count and top-of-stack read.
// Optional build macro: CTX_PARITY_EN (adds an even-parity bit per entry).
module ctx_stack_mem
  import ctx_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PC_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [PC_W-1:0]         pc_i,
  input  logic [MODE_W-1:0]       mode_i,
  output logic [PC_W-1:0]         top_pc_o,
  output logic [MODE_W-1:0]       top_mode_o,
`ifdef CTX_PARITY_EN
  output logic                    top_par_err_o,
`endif
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DATA_W = PC_W + MODE_W;
`ifdef CTX_PARITY_EN
  localparam int unsigned ENTRY_W = DATA_W + 1;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr, top_ptr;
  logic [DATA_W-1:0]  wdata;
  logic [ENTRY_W-1:0] wentry, top_entry;
  logic               do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  // Write slot is the current count; top is one below (don't-care when empty).
  assign wr_ptr  = PTR_W'(count_q);
  assign top_ptr = PTR_W'(count_q - CNT_W'(1));

  assign wdata = {pc_i, mode_i};
`ifdef CTX_PARITY_EN
  assign wentry        = {^wdata, wdata};
  assign top_par_err_o = ^top_entry;
`else
  assign wentry = wdata;
`endif

  assign top_entry  = mem_q[top_ptr];
  assign top_pc_o   = top_entry[DATA_W-1:MODE_W];
  assign top_mode_o = top_entry[MODE_W-1:0];
  assign count_o    = count_q;

  // Saturating occupancy update; push wins over pop.
  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_ptr] <= wentry;
    end
  end

endmodule

// File: rtl/context_stack.sv
// Handler context stack: saves {PC, Mode} on entry and redirects fetch on return.
// Optional build macro: CTX_PARITY_EN (parity-checked entries, faulting return).
module context_stack
  import ctx_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned PC_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Store_Current,
  input  logic [PC_W-1:0]        cur_PC,
  input  logic [MODE_W-1:0]      cur_Mode,
  input  logic                   rti_req,
  input  logic                   miss,
  input  logic                   IFID_Stall,
  output logic                   ret_J,
  output logic [PC_W-1:0]        ret_PC,
  output logic [MODE_W-1:0]      ret_Mode,
  output logic                   ret_Fault,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] depth
);

  ctx_state_e        state_q, state_d;
  logic              ret_j_q, ret_j_d;
  logic              fault_q, fault_d;
  logic              ovf_q, ovf_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              push_c, pop_c;
  logic              full_c, empty_c;
  logic [PC_W-1:0]   top_pc_c;
  logic [MODE_W-1:0] top_mode_c;
`ifdef CTX_PARITY_EN
  logic              top_par_err_c;
  logic              par_err_q, par_err_d;
`endif

  ctx_stack_mem #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_mem (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push_c),
    .pop_i         (pop_c),
    .pc_i          (cur_PC),
    .mode_i        (cur_Mode),
    .top_pc_o      (top_pc_c),
    .top_mode_o    (top_mode_c),
`ifdef CTX_PARITY_EN
    .top_par_err_o (top_par_err_c),
`endif
    .full_o        (full_c),
    .empty_o       (empty_c),
    .count_o       (depth)
  );

  // Next-state, stack control and registered-output values.
  always_comb begin
    state_d = state_q;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    ovf_d   = ovf_q;
    fault_d = 1'b0;
    ret_j_d = 1'b0;
    pc_d    = '0;
    mode_d  = '0;
`ifdef CTX_PARITY_EN
    par_err_d = 1'b0;
`endif

    if (Store_Current) begin
      push_c = !full_c;
      if (full_c) begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rti_req && !miss && !Store_Current) begin
          if (empty_c) begin
            fault_d = 1'b1;
          end else begin
            state_d = ST_RET;
`ifdef CTX_PARITY_EN
            par_err_d = top_par_err_c;
`endif
          end
        end
      end
      ST_RET, ST_HOLD: begin
        if (Store_Current) begin
          state_d = ST_IDLE;
`ifdef CTX_PARITY_EN
        end else if (par_err_q) begin
          pop_c   = 1'b1;
          state_d = ST_IDLE;
`endif
        end else if (miss) begin
          state_d = ST_IDLE;
        end else if (IFID_Stall) begin
          state_d = ST_HOLD;
        end else begin
          pop_c   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Redirect outputs track the state being entered; top is stable there.
    if (state_d != ST_IDLE) begin
      ret_j_d = 1'b1;
      pc_d    = top_pc_c;
      mode_d  = top_mode_c;
    end
`ifdef CTX_PARITY_EN
    if (par_err_d) begin
      ret_j_d = 1'b0;
      fault_d = 1'b1;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ret_j_q <= 1'b0;
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
      pc_q    <= '0;
      mode_q  <= '0;
`ifdef CTX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ret_j_q <= ret_j_d;
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
`ifdef CTX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign ret_J     = ret_j_q;
  assign ret_PC    = pc_q;
  assign ret_Mode  = mode_q;
  assign ret_Fault = fault_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_context_stack.sv
// Bench for context_stack: directed scenarios plus random traffic vs. a queue model.
module tb_context_stack;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 16;
  localparam int unsigned DW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, sc, rti, miss, stall;
  logic [PC_W-1:0]  cur_pc;
  logic [1:0]       cur_mode;
  logic             ret_J, ret_Fault, overflow;
  logic [PC_W-1:0]  ret_PC;
  logic [1:0]       ret_Mode;
  logic [DW-1:0]    depth;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [1:0]      mode;
  } ent_t;

  // Reference model: a queue of saved contexts and a "return in flight" flag.
  ent_t stk[$];
  bit   m_ret, m_ovf, m_fault;

  context_stack #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .Store_Current (sc),
    .cur_PC        (cur_pc),
    .cur_Mode      (cur_mode),
    .rti_req       (rti),
    .miss          (miss),
    .IFID_Stall    (stall),
    .ret_J         (ret_J),
    .ret_PC        (ret_PC),
    .ret_Mode      (ret_Mode),
    .ret_Fault     (ret_Fault),
    .overflow      (overflow),
    .depth         (depth)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit s, input bit q, input bit m,
                              input bit st, input logic [PC_W-1:0] pc,
                              input logic [1:0] md);
    bit   nf;
    ent_t e;
    nf = 1'b0;
    e  = {pc, md};
    if (r) begin
      stk.delete();
      m_ret = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (s) begin
        if (stk.size() < DEPTH) stk.push_back(e);
        else m_ovf = 1'b1;
        m_ret = 1'b0;
      end else if (m_ret) begin
        if (m) begin
          m_ret = 1'b0;
        end else if (!st) begin
          void'(stk.pop_back());
          m_ret = 1'b0;
        end
      end else if (q && !m) begin
        if (stk.size() == 0) nf = 1'b1;
        else m_ret = 1'b1;
      end
    end
    m_fault = nf;
  endtask

  task automatic compare_all();
    logic [PC_W-1:0] epc;
    logic [1:0]      emd;
    epc = '0;
    emd = '0;
    if (m_ret && stk.size() > 0) begin
      epc = stk[stk.size()-1].pc;
      emd = stk[stk.size()-1].mode;
    end
    check_eq("ret_J",     32'(ret_J),     32'(m_ret));
    check_eq("ret_PC",    32'(ret_PC),    32'(epc));
    check_eq("ret_Mode",  32'(ret_Mode),  32'(emd));
    check_eq("ret_Fault", 32'(ret_Fault), 32'(m_fault));
    check_eq("overflow",  32'(overflow),  32'(m_ovf));
    check_eq("depth",     32'(depth),     32'(stk.size()));
  endtask

  // One clock: drive at negedge, advance model at posedge, compare just after.
  task automatic step(input bit r, input bit s, input bit q, input bit m, input bit st,
                      input logic [PC_W-1:0] pc, input logic [1:0] md);
    rst = r; sc = s; rti = q; miss = m; stall = st; cur_pc = pc; cur_mode = md;
    @(posedge clk);
    model_update(r, s, q, m, st, pc, md);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic push(input logic [PC_W-1:0] pc, input logic [1:0] md);
    step(0, 1, 0, 0, 0, pc, md);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    rst = 1'b1; sc = 1'b0; rti = 1'b0; miss = 1'b0; stall = 1'b0;
    cur_pc = '0; cur_mode = '0;
    m_ret = 1'b0; m_ovf = 1'b0; m_fault = 1'b0;

    // Reset state.
    do_reset();
    do_reset();
    check_eq("rst_depth", 32'(depth), 32'd0);
    check_eq("rst_retj",  32'(ret_J), 32'd0);

    // Basic push then return.
    push(16'h1234, 2'b11);
    step(0, 0, 1, 0, 0, '0, '0);
    check_eq("basic_pc",   32'(ret_PC),   32'h1234);
    check_eq("basic_mode", 32'(ret_Mode), 32'h3);
    idle();
    check_eq("basic_depth", 32'(depth), 32'd0);
    check_eq("basic_retj",  32'(ret_J), 32'd0);

    // Stalled return: ret_J held for 4 cycles, single pop.
    push(16'h0010, 2'b01);
    push(16'h0020, 2'b10);
    step(0, 0, 1, 0, 1, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1, '0, '0);
      check_eq("hold_pc", 32'(ret_PC), 32'h0020);
    end
    idle();
    check_eq("hold_depth", 32'(depth), 32'd1);
    step(0, 0, 1, 0, 0, '0, '0);
    idle();

    // Overflow on fifth push.
    do_reset();
    for (int i = 1; i <= 5; i++) push(16'(i * 16'h0101), 2'(i));
    check_eq("ovf_flag",  32'(overflow), 32'd1);
    check_eq("ovf_depth", 32'(depth),    32'd4);
    step(0, 0, 1, 0, 0, '0, '0);
    check_eq("ovf_top", 32'(ret_PC), 32'h0404);
    idle();
    idle();
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Return from empty stack.
    do_reset();
    step(0, 0, 1, 0, 0, '0, '0);
    check_eq("empty_fault", 32'(ret_Fault), 32'd1);
    idle();
    check_eq("empty_fault_clr", 32'(ret_Fault), 32'd0);

    // Push wins over rti; miss cancels return; push during return.
    push(16'hAAAA, 2'b00);
    step(0, 1, 1, 0, 0, 16'hBBBB, 2'b01);
    check_eq("prio_depth", 32'(depth), 32'd2);
    check_eq("prio_retj",  32'(ret_J), 32'd0);
    step(0, 0, 1, 0, 0, '0, '0);
    step(0, 0, 0, 1, 0, '0, '0);
    check_eq("miss_depth", 32'(depth), 32'd2);
    step(0, 0, 1, 0, 0, '0, '0);
    push(16'hCCCC, 2'b10);
    idle();
    check_eq("push_in_ret", 32'(depth), 32'd3);
    step(0, 0, 1, 0, 1, '0, '0);
    step(1, 0, 0, 0, 0, '0, '0);
    check_eq("rst_mid_ret", 32'(depth), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) == 0),
           16'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
